// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings, error codes and FSM states for the LSU
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_FUNCT3   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } lsu_state_t;

    // Unsigned variants have no store form, and 011/11x are not LSU encodings here.
    function automatic logic f3_illegal(input logic [2:0] f3, input logic is_store);
        logic bad;
        bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (f3[2] && is_store);
        return bad;
    endfunction

    // Halfwords need an even address, words need a 4-byte aligned address.
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        case (f3)
            F3_H, F3_HU: mis = off[0];
            F3_W:        mis = (off != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - store lane replication/byte mask and load extract/extend
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int OFF_W = $clog2(XLEN / 8),
    localparam int MASK_W = XLEN / 8
) (
    input  logic              st_is_store,
    input  logic [2:0]        st_funct3,
    input  logic [OFF_W-1:0]  st_off,
    input  logic [XLEN-1:0]   st_data,
    output logic [XLEN-1:0]   st_wdata,
    output logic [MASK_W-1:0] st_wmask,
    input  logic [2:0]        ld_funct3,
    input  logic [OFF_W-1:0]  ld_off,
    input  logic [XLEN-1:0]   ld_word,
    output logic [XLEN-1:0]   ld_result
);

    logic [XLEN-1:0] shifted;

    assign shifted = ld_word >> {ld_off, 3'b000};

    // Store data is replicated across every lane so the mask alone selects the target bytes.
    always_comb begin
        st_wdata = '0;
        st_wmask = '0;
        if (st_is_store) begin
            case (st_funct3)
                F3_B: begin
                    st_wdata = {MASK_W{st_data[7:0]}};
                    st_wmask = MASK_W'(1) << st_off;
                end
                F3_H: begin
                    st_wdata = {(XLEN / 16){st_data[15:0]}};
                    st_wmask = MASK_W'(3) << st_off;
                end
                F3_W: begin
                    st_wdata = st_data;
                    st_wmask = '1;
                end
                default: begin
                    st_wdata = '0;
                    st_wmask = '0;
                end
            endcase
        end
    end

    // Bring the addressed lane down to bit 0, then sign- or zero-extend by funct3[2].
    always_comb begin
        ld_result = '0;
        case (ld_funct3)
            F3_B:    ld_result = {{(XLEN - 8){shifted[7]}}, shifted[7:0]};
            F3_H:    ld_result = {{(XLEN - 16){shifted[15]}}, shifted[15:0]};
            F3_W:    ld_result = shifted;
            F3_BU:   ld_result = {{(XLEN - 8){1'b0}}, shifted[7:0]};
            F3_HU:   ld_result = {{(XLEN - 16){1'b0}}, shifted[15:0]};
            default: ld_result = '0;
        endcase
    end

endmodule

// File: rtl/lsu_multicycle.sv
// rtl/lsu_multicycle.sv - multi-cycle load/store unit with memory handshake and timeout
module lsu_multicycle
    import lsu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ADDR_W = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                lsu_valid,
    output logic                lsu_ready,
    input  logic                lsu_is_store,
    input  logic [2:0]          lsu_funct3,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic [XLEN-1:0]     lsu_wdata,
    output logic                lsu_done,
    output logic [XLEN-1:0]     lsu_rdata,
    output logic                lsu_err,
    output logic [1:0]          lsu_err_code,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic                mem_req_wen,
    output logic [XLEN-1:0]     mem_req_wdata,
    output logic [XLEN/8-1:0]   mem_req_wmask,
    input  logic                mem_rsp_valid,
    input  logic [XLEN-1:0]     mem_rsp_rdata
);

    localparam int OFF_W = $clog2(XLEN / 8);
    localparam int MASK_W = XLEN / 8;
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    lsu_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             r_is_store;
    logic [2:0]       r_funct3;
    logic [OFF_W-1:0] r_off;

    logic [XLEN-1:0]   st_wdata;
    logic [MASK_W-1:0] st_wmask;
    logic [XLEN-1:0]   ld_result;
    logic              acc_illegal;
    logic              acc_misaligned;

    assign acc_illegal    = f3_illegal(lsu_funct3, lsu_is_store);
    assign acc_misaligned = f3_misaligned(lsu_funct3, lsu_addr[1:0]);

    lsu_lane_align #(
        .XLEN(XLEN)
    ) u_lane_align (
        .st_is_store (lsu_is_store),
        .st_funct3   (lsu_funct3),
        .st_off      (lsu_addr[OFF_W-1:0]),
        .st_data     (lsu_wdata),
        .st_wdata    (st_wdata),
        .st_wmask    (st_wmask),
        .ld_funct3   (r_funct3),
        .ld_off      (r_off),
        .ld_word     (mem_rsp_rdata),
        .ld_result   (ld_result)
    );

    // Operation FSM: accept/decode in IDLE, hold the request in REQ, wait or time out, pulse done.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            r_is_store    <= 1'b0;
            r_funct3      <= '0;
            r_off         <= '0;
            lsu_ready     <= 1'b0;
            lsu_done      <= 1'b0;
            lsu_rdata     <= '0;
            lsu_err       <= 1'b0;
            lsu_err_code  <= ERR_NONE;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wen   <= 1'b0;
            mem_req_wdata <= '0;
            mem_req_wmask <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (lsu_valid && lsu_ready) begin
                        lsu_ready  <= 1'b0;
                        r_is_store <= lsu_is_store;
                        r_funct3   <= lsu_funct3;
                        r_off      <= lsu_addr[OFF_W-1:0];
                        if (acc_illegal) begin
                            state        <= ST_DONE;
                            lsu_done     <= 1'b1;
                            lsu_err      <= 1'b1;
                            lsu_err_code <= ERR_FUNCT3;
                            lsu_rdata    <= '0;
                        end else if (acc_misaligned) begin
                            state        <= ST_DONE;
                            lsu_done     <= 1'b1;
                            lsu_err      <= 1'b1;
                            lsu_err_code <= ERR_MISALIGN;
                            lsu_rdata    <= '0;
                        end else begin
                            state         <= ST_REQ;
                            mem_req_valid <= 1'b1;
                            mem_req_addr  <= {lsu_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                            mem_req_wen   <= lsu_is_store;
                            mem_req_wdata <= st_wdata;
                            mem_req_wmask <= st_wmask;
                        end
                    end else begin
                        lsu_ready <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        state         <= ST_WAIT;
                        cnt           <= '0;
                        mem_req_valid <= 1'b0;
                        mem_req_addr  <= '0;
                        mem_req_wen   <= 1'b0;
                        mem_req_wdata <= '0;
                        mem_req_wmask <= '0;
                    end
                end
                ST_WAIT: begin
                    if (mem_rsp_valid) begin
                        state        <= ST_DONE;
                        lsu_done     <= 1'b1;
                        lsu_err      <= 1'b0;
                        lsu_err_code <= ERR_NONE;
                        lsu_rdata    <= r_is_store ? '0 : ld_result;
                    end else if (cnt == CNT_LAST) begin
                        state        <= ST_DONE;
                        lsu_done     <= 1'b1;
                        lsu_err      <= 1'b1;
                        lsu_err_code <= ERR_TIMEOUT;
                        lsu_rdata    <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state        <= ST_IDLE;
                    lsu_done     <= 1'b0;
                    lsu_err      <= 1'b0;
                    lsu_err_code <= ERR_NONE;
                    lsu_rdata    <= '0;
                    lsu_ready    <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_multicycle.sv
// tb/tb_lsu_multicycle.sv - self-checking bench for lsu_multicycle
module tb_lsu_multicycle;

    localparam int TMO = 8;

    logic        clk;
    logic        rst;
    logic        lsu_valid;
    logic        lsu_ready;
    logic        lsu_is_store;
    logic [2:0]  lsu_funct3;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic        lsu_done;
    logic [31:0] lsu_rdata;
    logic        lsu_err;
    logic [1:0]  lsu_err_code;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_req_wen;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wmask;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;

    int n_checks = 0;
    int n_fail = 0;

    lsu_multicycle #(
        .XLEN(32),
        .ADDR_W(32),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .lsu_valid     (lsu_valid),
        .lsu_ready     (lsu_ready),
        .lsu_is_store  (lsu_is_store),
        .lsu_funct3    (lsu_funct3),
        .lsu_addr      (lsu_addr),
        .lsu_wdata     (lsu_wdata),
        .lsu_done      (lsu_done),
        .lsu_rdata     (lsu_rdata),
        .lsu_err       (lsu_err),
        .lsu_err_code  (lsu_err_code),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wen   (mem_req_wen),
        .mem_req_wdata (mem_req_wdata),
        .mem_req_wmask (mem_req_wmask),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_rdata (mem_rsp_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] word;
        int          rdy;
        int          rsp;
        int          lat;
        logic [31:0] rd;
        logic        err;
        logic [1:0]  code;
        logic [3:0]  mask;
        logic [31:0] mwd;
    } vec_t;

    typedef struct {
        int          lat;
        logic [31:0] rd;
        logic        err;
        logic [1:0]  code;
        logic        req;
        logic [31:0] addr;
        logic        wen;
        logic [3:0]  mask;
        logic [31:0] wd;
        logic        stable;
        logic        busy_rdy;
    } res_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, ".ready"}, 32'(lsu_ready), 32'd0);
        chk({tag, ".done"}, 32'(lsu_done), 32'd0);
        chk({tag, ".err"}, 32'(lsu_err), 32'd0);
        chk({tag, ".code"}, 32'(lsu_err_code), 32'd0);
        chk({tag, ".rdata"}, lsu_rdata, 32'd0);
        chk({tag, ".req_valid"}, 32'(mem_req_valid), 32'd0);
        chk({tag, ".req_addr"}, mem_req_addr, 32'd0);
        chk({tag, ".req_wen"}, 32'(mem_req_wen), 32'd0);
        chk({tag, ".req_wdata"}, mem_req_wdata, 32'd0);
        chk({tag, ".req_wmask"}, 32'(mem_req_wmask), 32'd0);
    endtask

    // Reference model: outcome of one operation from size/offset arithmetic and handshake delays.
    task automatic model(inout vec_t v);
        int     nbytes;
        int     off;
        logic   illegal;
        longint w;
        nbytes = 1 << int'(v.f3[1:0]);
        off = int'(v.addr % 4);
        illegal = (v.f3 == 3'd3) || (v.f3 == 3'd6) || (v.f3 == 3'd7) || (v.st && v.f3 >= 3'd4);
        v.rd = 32'd0;
        v.mask = 4'd0;
        v.mwd = 32'd0;
        v.err = 1'b0;
        v.code = 2'd0;
        if (illegal) begin
            v.lat = 1; v.err = 1'b1; v.code = 2'd3;
        end else if (off % nbytes != 0) begin
            v.lat = 1; v.err = 1'b1; v.code = 2'd1;
        end else begin
            if (v.st) begin
                v.mask = 4'(((1 << nbytes) - 1) << off);
                if (nbytes == 1) v.mwd = 32'(v.wd[7:0]) * 32'h01010101;
                else if (nbytes == 2) v.mwd = 32'(v.wd[15:0]) * 32'h00010001;
                else v.mwd = v.wd;
            end
            if (v.rsp < 0) begin
                v.lat = 2 + v.rdy + TMO; v.err = 1'b1; v.code = 2'd2;
            end else begin
                v.lat = 3 + v.rdy + v.rsp;
                if (!v.st) begin
                    w = (longint'(v.word) >> (8 * off)) & ((64'sd1 <<< (8 * nbytes)) - 1);
                    if (!v.f3[2] && w >= (64'sd1 <<< (8 * nbytes - 1))) w = w - (64'sd1 <<< (8 * nbytes));
                    v.rd = w[31:0];
                end
            end
        end
    endtask

    // Issue one op from IDLE and play the memory side; returns at the first IDLE cycle after done.
    task automatic run_op(input vec_t v, output res_t r);
        int   c;
        int   rq;
        int   wcnt;
        logic phase_wait;
        logic got;
        r = '{lat: -1, rd: 32'd0, err: 1'b0, code: 2'd0, req: 1'b0, addr: 32'd0,
              wen: 1'b0, mask: 4'd0, wd: 32'd0, stable: 1'b1, busy_rdy: 1'b0};
        chk("idle_ready", 32'(lsu_ready), 32'd1);
        lsu_valid = 1'b1;
        lsu_is_store = v.st;
        lsu_funct3 = v.f3;
        lsu_addr = v.addr;
        lsu_wdata = v.wd;
        @(negedge clk);
        lsu_valid = 1'b0;
        lsu_wdata = $urandom;
        lsu_addr = $urandom;
        c = 1; rq = 0; wcnt = 0; phase_wait = 1'b0; got = 1'b0;
        while (c <= 400 && !got) begin
            if (lsu_ready) r.busy_rdy = 1'b1;
            if (lsu_done) begin
                got = 1'b1;
                r.lat = c;
                r.rd = lsu_rdata;
                r.err = lsu_err;
                r.code = lsu_err_code;
            end else begin
                mem_req_ready = 1'b0;
                mem_rsp_valid = 1'b0;
                if (phase_wait) begin
                    if (mem_req_valid) r.stable = 1'b0;
                    mem_rsp_valid = (v.rsp >= 0 && wcnt == v.rsp);
                    mem_rsp_rdata = v.word;
                    wcnt++;
                end else if (mem_req_valid) begin
                    if (!r.req) begin
                        r.req = 1'b1;
                        r.addr = mem_req_addr;
                        r.wen = mem_req_wen;
                        r.mask = mem_req_wmask;
                        r.wd = mem_req_wdata;
                    end else if (r.addr !== mem_req_addr || r.wen !== mem_req_wen ||
                                 r.mask !== mem_req_wmask || r.wd !== mem_req_wdata) begin
                        r.stable = 1'b0;
                    end
                    if (rq >= v.rdy) begin
                        mem_req_ready = 1'b1;
                        phase_wait = 1'b1;
                    end else begin
                        mem_rsp_valid = 1'($urandom_range(0, 1));
                        mem_rsp_rdata = $urandom;
                    end
                    rq++;
                end
                @(negedge clk);
                c++;
            end
        end
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_op(input string tag, input vec_t v, input res_t r);
        chk({tag, ".lat"}, 32'(r.lat), 32'(v.lat));
        chk({tag, ".rdata"}, r.rd, v.rd);
        chk({tag, ".err"}, 32'(r.err), 32'(v.err));
        chk({tag, ".code"}, 32'(r.code), 32'(v.code));
        chk({tag, ".req_issued"}, 32'(r.req), 32'(v.lat > 1));
        chk({tag, ".ready_busy"}, 32'(r.busy_rdy), 32'd0);
        if (v.lat > 1) begin
            chk({tag, ".req_addr"}, r.addr, {v.addr[31:2], 2'b00});
            chk({tag, ".req_wen"}, 32'(r.wen), 32'(v.st));
            chk({tag, ".req_wmask"}, 32'(r.mask), 32'(v.mask));
            chk({tag, ".req_stable"}, 32'(r.stable), 32'd1);
            if (v.st) chk({tag, ".req_wdata"}, r.wd, v.mwd);
        end
    endtask

    vec_t tbl[12];
    vec_t e;
    res_t r;

    initial begin
        // st, f3, addr, wdata, mem word, ready delay, rsp delay(-1 never), lat, rdata, err, code, wmask, wdata
        tbl[0]  = '{1'b0, 3'd0, 32'h80000003, 32'h0,        32'h80FF0000, 0, 0,  3,  32'hFFFFFF80, 1'b0, 2'd0, 4'h0, 32'h0};
        tbl[1]  = '{1'b0, 3'd5, 32'h80000002, 32'h0,        32'hBEEF1234, 4, 0,  7,  32'h0000BEEF, 1'b0, 2'd0, 4'h0, 32'h0};
        tbl[2]  = '{1'b1, 3'd0, 32'h80000001, 32'h000000AB, 32'h0,        0, 0,  3,  32'h0,        1'b0, 2'd0, 4'h2, 32'hABABABAB};
        tbl[3]  = '{1'b0, 3'd2, 32'h80000002, 32'h0,        32'h0,        0, 0,  1,  32'h0,        1'b1, 2'd1, 4'h0, 32'h0};
        tbl[4]  = '{1'b0, 3'd2, 32'h80000000, 32'h0,        32'h12345678, 0, -1, 10, 32'h0,        1'b1, 2'd2, 4'h0, 32'h0};
        tbl[5]  = '{1'b0, 3'd1, 32'h80000000, 32'h0,        32'h00008001, 1, 2,  6,  32'hFFFF8001, 1'b0, 2'd0, 4'h0, 32'h0};
        tbl[6]  = '{1'b1, 3'd1, 32'h80000002, 32'h1234CAFE, 32'h0,        0, 0,  3,  32'h0,        1'b0, 2'd0, 4'hC, 32'hCAFECAFE};
        tbl[7]  = '{1'b0, 3'd3, 32'h80000000, 32'h0,        32'h0,        0, 0,  1,  32'h0,        1'b1, 2'd3, 4'h0, 32'h0};
        tbl[8]  = '{1'b1, 3'd4, 32'h80000000, 32'h55,       32'h0,        0, 0,  1,  32'h0,        1'b1, 2'd3, 4'h0, 32'h0};
        tbl[9]  = '{1'b0, 3'd5, 32'h80000003, 32'h0,        32'h0,        0, 0,  1,  32'h0,        1'b1, 2'd1, 4'h0, 32'h0};
        tbl[10] = '{1'b1, 3'd2, 32'h80000004, 32'hDEADBEEF, 32'h0,        2, 1,  6,  32'h0,        1'b0, 2'd0, 4'hF, 32'hDEADBEEF};
        tbl[11] = '{1'b0, 3'd4, 32'h80000001, 32'h0,        32'h00009A00, 0, 3,  6,  32'h0000009A, 1'b0, 2'd0, 4'h0, 32'h0};

        rst = 1'b0;
        lsu_valid = 1'b0;
        lsu_is_store = 1'b0;
        lsu_funct3 = 3'd0;
        lsu_addr = 32'd0;
        lsu_wdata = 32'd0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = 32'd0;
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 32'(lsu_ready), 32'd1);

        for (int i = 0; i < 12; i++) begin
            run_op(tbl[i], r);
            check_op($sformatf("vec%0d", i), tbl[i], r);
        end

        // Late response while idle must be dropped.
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        chk("late_rsp.done", 32'(lsu_done), 32'd0);
        chk("late_rsp.ready", 32'(lsu_ready), 32'd1);
        chk("late_rsp.req", 32'(mem_req_valid), 32'd0);

        // Valid held high across an error completion: next accept only once back in IDLE.
        lsu_valid = 1'b1;
        lsu_is_store = 1'b0;
        lsu_funct3 = 3'd2;
        lsu_addr = 32'h80000001;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk($sformatf("held_valid.done%0d", k), 32'(lsu_done), 32'(k % 2));
            chk($sformatf("held_valid.ready%0d", k), 32'(lsu_ready), 32'((k + 1) % 2));
            if (k == 4) lsu_valid = 1'b0;
        end

        // Reset during WAIT abandons the op.
        lsu_valid = 1'b1;
        lsu_funct3 = 3'd2;
        lsu_addr = 32'h80000010;
        @(negedge clk);
        lsu_valid = 1'b0;
        chk("rst_mid.req_valid", 32'(mem_req_valid), 32'd1);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        chk("rst_mid.in_wait", 32'(mem_req_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk_outputs_zero("rst_mid");
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid.ready_after", 32'(lsu_ready), 32'd1);
        chk("rst_mid.no_done", 32'(lsu_done), 32'd0);
        e = '{1'b0, 3'd2, 32'h80000020, 32'h0, 32'h11223344, 0, 0, 0, 32'h0, 1'b0, 2'd0, 4'h0, 32'h0};
        model(e);
        run_op(e, r);
        check_op("rst_mid.lw", e, r);

        for (int i = 0; i < 40; i++) begin
            e.st = 1'($urandom_range(0, 1));
            e.f3 = 3'($urandom_range(0, 7));
            e.addr = $urandom;
            e.wd = $urandom;
            e.word = $urandom;
            e.rdy = $urandom_range(0, 3);
            e.rsp = ($urandom_range(0, 5) == 0) ? -1 : $urandom_range(0, 3);
            model(e);
            run_op(e, r);
            check_op($sformatf("rnd%0d", i), e, r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_multicycle.md
Name: lsu_multicycle

Overview:
- Multi-cycle load/store unit between the NPC execute stage and data memory; replaces the always-valid, same-cycle DPI read path.
- Core side: one LSU operation per valid/ready handshake.
- Memory side: word-aligned request/response handshake (DPI-backed bench model or future bus bridge).
- Owns byte-lane selection, write-mask generation, load sign/zero extension, misalignment detection and a response timeout.

Parameters:
- XLEN, 32: data width; RTL must support 32 (64 reserved).
- ADDR_W, 32: address width.
- TIMEOUT_CYC, 255: maximum WAIT cycles before a timeout error; must be >= 1.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-low reset.
- lsu_valid  in  1  core presents an operation.
- lsu_ready  out  1  unit can accept; high only in IDLE.
- lsu_is_store  in  1  1 = store, 0 = load.
- lsu_funct3  in  3  RV funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- lsu_addr  in  ADDR_W  byte address.
- lsu_wdata  in  XLEN  store data, right-aligned.
- lsu_done  out  1  one-cycle completion pulse.
- lsu_rdata  out  XLEN  extended load result; valid while lsu_done=1.
- lsu_err  out  1  valid while lsu_done=1.
- lsu_err_code  out  2  00 none, 01 misaligned, 10 timeout, 11 illegal funct3.
- mem_req_valid  out  1  memory request.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_addr  out  ADDR_W  lsu_addr with low log2(XLEN/8) bits cleared.
- mem_req_wen  out  1  write request.
- mem_req_wdata  out  XLEN  store data shifted to its byte lane.
- mem_req_wmask  out  XLEN/8  byte-enable mask.
- mem_rsp_valid  in  1  response/ack; one pulse per request.
- mem_rsp_rdata  in  XLEN  full word read.

Behaviour:
- Reset:
  - rst==0 at a posedge → state IDLE, counter 0, every output 0.
  - lsu_ready becomes 1 the cycle after rst is released.
  - Reset mid-operation abandons the transaction: no lsu_done, mem_req_valid drops next cycle.
- States and transitions:
  - IDLE: lsu_ready=1. lsu_valid at posedge latches is_store, funct3, addr, wdata.
    - funct3 in {011, 110, 111}, or 1xx with is_store → DONE, code 11.
    - Misaligned (H/HU with addr[0]≠0; W with addr[1:0]≠0) → DONE, code 01.
    - Otherwise → REQ.
    - In both error cases no memory request is issued.
  - REQ:
    - mem_req_valid=1; addr, wen, wdata and wmask held stable until mem_req_ready.
    - mem_req_ready=1 at posedge → WAIT, counter cleared.
    - mem_rsp_valid in REQ is ignored.
  - WAIT:
    - mem_rsp_valid=1 → capture and extract → DONE, code 00.
    - Otherwise the counter increments; counter==TIMEOUT_CYC-1 without a response → DONE, code 10, lsu_rdata=0.
  - DONE:
    - lsu_done=1 for exactly one cycle, then → IDLE.
    - lsu_ready=0; a new lsu_valid is not accepted until IDLE.
- Latency:
  - Accept edge t; REQ during cycle t+1; with ready=1 immediately, WAIT during t+2.
  - With rsp in that cycle, lsu_done is high in cycle t+3. Minimum is 3 cycles.
  - Error completions: lsu_done in cycle t+1.
- Lanes (off = addr[1:0]):
  - SB: wmask = 4'b0001<<off, wdata = {4{wdata[7:0]}}.
  - SH: wmask = 4'b0011<<off, wdata = {2{wdata[15:0]}}.
  - SW: wmask = 4'hF.
  - Loads: wen=0, wmask=0.
- Load extract:
  - byte = rdata >> (8*off), half = rdata >> (8*off).
  - funct3[2]=0 sign-extends, 1 zero-extends.
  - Stores complete with lsu_rdata=0.
- Any late mem_rsp_valid arriving in IDLE or DONE is dropped.

Decomposition:
- Shared package lsu_pkg: funct3 encodings, err_code constants, state enum (IDLE, REQ, WAIT, DONE).
- One natural sub-module, lsu_lane_align: combinational wmask/wdata shift and load extract/extend.
- The FSM, counter and registers live in the top module.

Test Plan:
- LB, addr 0x80000003, rdata 0x80FF0000, ready/rsp immediate → mem_req_addr 0x80000000; lsu_done at t+3, rdata 0xFFFFFF80, err 0.
- LHU, addr 0x80000002, rdata 0xBEEF1234, ready delayed 4 cycles → request held stable; rdata 0x0000BEEF, done at t+7.
- SB, addr 0x80000001, wdata 0x000000AB → wen=1, wmask 4'b0010, wdata[15:8]=0xAB; done after ack, rdata 0.
- LW, addr 0x80000002 → no mem_req_valid; done at t+1, err=1, code 01.
- LW with TIMEOUT_CYC=8, rsp never → done exactly 8 WAIT cycles after entry, code 10; next op accepted normally.
- Reset (rst=0) asserted during WAIT → all outputs 0 next cycle, no lsu_done; a subsequent LW completes correctly.
